// File: rtl/rede_out_collector.sv
// Output collector: captures strobed float2int results into a frame, runs a sequential argmax, and hands the frame to the host.
// Define REDE_OUT_SAT_EN to saturate the DW->OW conversion; otherwise the low OW bits are kept.
module rede_out_collector #(
    parameter int NOUT = 4,
    parameter int DW   = 28,
    parameter int OW   = 16,
    parameter int CW   = $clog2(NOUT)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DW-1:0]        io_out,
    input  logic [NOUT-1:0]      out_en,
    input  logic                 err_clr,
    input  logic                 m_ready,
    output logic                 m_valid,
    output logic [NOUT*OW-1:0]   m_data,
    output logic [CW-1:0]        m_class,
    output logic [OW-1:0]        m_max,
    output logic                 dup_err,
    output logic                 ovf_err
);

    typedef enum logic [1:0] {IDLE, SCAN, HOLD} state_t;

    state_t state, state_nxt;

    logic signed [DW-1:0] io_word;
    logic signed [DW-1:0] slot_p0 [NOUT];
    logic [NOUT-1:0]      mask_p0;

    logic signed [DW-1:0] work_p1 [NOUT];
    logic [CW-1:0]        k_p1;
    logic [CW-1:0]        best_idx_p1;
    logic signed [DW-1:0] best_val_p1;

    logic                 frame_full;
    logic                 work_free;
    logic                 copy_go;
    logic                 scan_last;
    logic                 dup_hit;
    logic                 ovf_hit;
    logic signed [DW-1:0] cand;
    logic                 take;
    logic [CW-1:0]        best_idx_nxt;
    logic signed [DW-1:0] best_val_nxt;

    function automatic logic [OW-1:0] to_ow(input logic signed [DW-1:0] v);
`ifdef REDE_OUT_SAT_EN
        logic signed [DW-1:0] hi;
        logic signed [DW-1:0] lo;
        hi = {{(DW-OW+1){1'b0}}, {(OW-1){1'b1}}};
        lo = {{(DW-OW+1){1'b1}}, {(OW-1){1'b0}}};
        if (v > hi)
            return OW'(hi);
        else if (v < lo)
            return OW'(lo);
        else
            return OW'(v);
`else
        return OW'(v);
`endif
    endfunction

    assign io_word    = io_out;
    assign frame_full = &mask_p0;
    assign work_free  = (state == IDLE) || ((state == HOLD) && m_ready);
    assign copy_go    = frame_full && work_free;
    assign scan_last  = (state == SCAN) && (k_p1 == CW'(NOUT-1));
    assign m_valid    = (state == HOLD);

    // Once the mask is full every strobe is dropped, including the one on the copy edge.
    assign dup_hit = !frame_full && |(out_en & mask_p0);
    assign ovf_hit = frame_full && |out_en;

    assign cand         = work_p1[k_p1];
    assign take         = cand > best_val_p1;
    assign best_idx_nxt = take ? k_p1 : best_idx_p1;
    assign best_val_nxt = take ? cand : best_val_p1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (copy_go) state_nxt = SCAN;
            SCAN:    if (scan_last) state_nxt = HOLD;
            HOLD:    if (m_ready) state_nxt = frame_full ? SCAN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Stage p0: capture slots and the written mask
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NOUT; i++)
                slot_p0[i] <= '0;
            mask_p0 <= '0;
        end else if (copy_go) begin
            mask_p0 <= '0;
        end else if (!frame_full) begin
            for (int i = 0; i < NOUT; i++) begin
                if (out_en[i]) begin
                    slot_p0[i] <= io_word;
                    mask_p0[i] <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dup_err <= 1'b0;
            ovf_err <= 1'b0;
        end else begin
            dup_err <= (dup_err && !err_clr) || dup_hit;
            ovf_err <= (ovf_err && !err_clr) || ovf_hit;
        end
    end

    // Stage p1: work copy and sequential argmax, slot 0 seeds the running best
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NOUT; i++)
                work_p1[i] <= '0;
            k_p1        <= '0;
            best_idx_p1 <= '0;
            best_val_p1 <= '0;
        end else if (copy_go) begin
            for (int i = 0; i < NOUT; i++)
                work_p1[i] <= slot_p0[i];
            k_p1        <= CW'(1);
            best_idx_p1 <= '0;
            best_val_p1 <= slot_p0[0];
        end else if (state == SCAN) begin
            k_p1        <= k_p1 + CW'(1);
            best_idx_p1 <= best_idx_nxt;
            best_val_p1 <= best_val_nxt;
        end
    end

    // Stage p2: presented frame, loaded on the last comparison edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_data  <= '0;
            m_class <= '0;
            m_max   <= '0;
        end else if (scan_last) begin
            for (int i = 0; i < NOUT; i++)
                m_data[i*OW +: OW] <= to_ow(work_p1[i]);
            m_class <= best_idx_nxt;
            m_max   <= to_ow(best_val_nxt);
        end
    end

endmodule

// File: doc/rede_out_collector.md
Name: rede_out_collector

Overview:
- Downstream stage of the float network core, fed by its float2int output and output-address decoder.
- Captures the 28-bit signed integer results strobed by the one-hot `out_en` lines and assembles them into a NOUT-word frame.
- Runs a sequential argmax over the frame to select the winning class.
- Presents the frame, class index and max value to the host side over a valid/ready handshake.
- Double-buffered: collection of the next frame continues while the previous one is being scanned or held.

Parameters:
- NOUT, 4: number of network outputs (out_en width, frame size).
- DW, 28: input word width (signed), matches the float2int output.
- OW, 16: output word width per frame element (signed).
- CW, $clog2(NOUT): class index width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- io_out  in  DW  signed result word from float2int.
- out_en  in  NOUT  one-hot write strobe per output slot.
- err_clr  in  1  synchronous pulse; clears sticky error flags.
- m_ready  in  1  downstream accepts the frame.
- m_valid  out  1  frame available.
- m_data  out  NOUT*OW  frame; slot i occupies bits [i*OW +: OW].
- m_class  out  CW  argmax index.
- m_max  out  OW  converted value of the winning slot.
- dup_err  out  1  sticky: a slot was written twice within one frame.
- ovf_err  out  1  sticky: a sample was dropped (overrun).

Behaviour:
- Reset (rst=0, async): slots, mask, work regs, m_data, m_class, m_max, m_valid, dup_err, ovf_err all 0; FSM to IDLE. Reset mid-frame discards any partial frame.
- Capture stage:
  - On each edge, every set bit i of out_en writes io_out into slot[i] and sets mask[i].
  - Multi-bit out_en writes all set slots with the same value; no flag.
  - Writing a slot whose mask bit is already set (mask not full) overwrites it and sets dup_err.
- Frame complete: mask == all ones. "Work free" = (state==IDLE) or (state==HOLD and m_ready).
  - Complete and work free: at the next edge, copy slots to work regs, clear mask, go to SCAN with best=0, bestval=slot0, k=1.
  - Complete and work not free: the frame stays pending. Any out_en asserted while pending drops that sample and sets ovf_err; slots and mask are unchanged.
  - A strobe in the same cycle as the copy edge is dropped (ovf_err). The processor's instruction spacing guarantees this cannot occur in normal operation.
- FSM:
  - IDLE: m_valid=0.
  - SCAN: each edge compares work[k] > bestval as DW-bit signed; strictly greater updates best/bestval. Ties keep the lower index. k increments.
  - After comparing k=NOUT-1: load m_data (converted work regs), m_class=best, m_max=converted bestval, set m_valid=1, go to HOLD. Total SCAN duration is NOUT-1 edges.
  - HOLD: m_valid=1 and outputs stable until m_ready.
    - m_ready with a pending frame: reload work regs and go to SCAN (m_valid drops to 0).
    - m_ready with no pending frame: go to IDLE (m_valid=0).
- Latency: the edge sampling the last strobe is E0; with work free, m_valid rises at edge E0+NOUT (4 for the default).
- Throughput: one frame per NOUT cycles when m_ready is held high.
- Width conversion DW→OW: truncation to the low OW bits (see optional feature). Argmax always uses the full DW value.
- err_clr clears dup_err and ovf_err. If err_clr and a new error occur in the same cycle, the error wins.

Optional Feature:
- Macro: REDE_OUT_SAT_EN.
- Defined: DW→OW conversion saturates to [-2^(OW-1), 2^(OW-1)-1] for both m_data and m_max.
- Undefined: plain two's-complement truncation to the low OW bits. No saturation logic is instantiated.

Test Plan:
- Reset: drive rst=0 mid-frame (slots 0,1 written) → all outputs 0. After release, writing only slots 2,3 does not produce m_valid.
- Basic frame: with m_ready=1, write slots 0..3 with 10, -5, 300, 7 on consecutive cycles → m_valid pulses 1 cycle, 4 edges after the slot-3 strobe; m_class=2, m_max=300, m_data={7,300,-5,10}.
- Tie: slot values 5, 9, 9, 1 → m_class=1, m_max=9.
- Backpressure and overrun (m_ready=0):
  - Frame A {1,2,3,4} is presented (class 3).
  - Frame B {8,0,0,0} completes and stays pending.
  - A further strobe on slot 0 → ovf_err=1; frame B is unchanged.
  - Raise m_ready → A accepted; B presented 3 edges later with class 0.
- Duplicate: write slot 1 with 3 then 8, then slots 0, 2, 3 with 0 → dup_err=1, m_data slot1=8, m_class=1. Pulse err_clr → dup_err=0.
- Conversion of slot values 40000 and -70000:
  - With REDE_OUT_SAT_EN: 32767 and -32768.
  - Without: 0x9C40 (-25536) and 0xEE90 (-4464).
  - In both builds, the slot holding 40000 is chosen as argmax over the other two slots at 0.
